// File: rtl/rgb_mixer_pkg.sv
// Shared widths, types and the quadrature step decoder for the RGB mixer.
package rgb_mixer_pkg;

    localparam int unsigned WIDTH        = 8;
    localparam int unsigned DEBOUNCE_LEN = 8;

    typedef logic [WIDTH-1:0] level_t;

    typedef enum logic [1:0] {
        StepNone,
        StepInc,
        StepDec
    } step_e;

    // Half-step decoder: only the A edges count up and only the B edges count down.
    // A full detent therefore moves the value by two.
    function automatic step_e quad_step(input logic a, input logic b,
                                        input logic a_prev, input logic b_prev);
        step_e step;
        step = StepNone;
        if ((a ^ a_prev) && (b ^ b_prev)) begin
            step = StepNone;
        end else if (a && !a_prev && !b) begin
            step = StepInc;
        end else if (!a && a_prev && b) begin
            step = StepInc;
        end else if (b && !b_prev && !a) begin
            step = StepDec;
        end else if (!b && b_prev && a) begin
            step = StepDec;
        end
        return step;
    endfunction

endpackage

// File: rtl/rgb_mixer_channel.sv
// One colour channel: sync and debounce of both encoder phases, quadrature decode,
// level register and registered PWM compare against the shared counter.
module rgb_mixer_channel
    import rgb_mixer_pkg::*;
#(
    parameter int unsigned DebounceLen = DEBOUNCE_LEN
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   enc_a_i,
    input  logic   enc_b_i,
    input  level_t counter_i,
    output logic   pwm_o
);

    // Bit 0 carries phase A, bit 1 carries phase B.
    logic [1:0]             raw;
    logic [1:0]             sync1_q;
    logic [1:0]             sync2_q;
    logic [DebounceLen-1:0] hist_q [2];
    logic [1:0]             level_q;
    logic [1:0]             level_d;
    logic [1:0]             prev_q;
    level_t                 value_q;
    level_t                 value_d;
    logic                   pwm_q;
    logic                   pwm_d;
    step_e                  step;

    assign raw = {enc_b_i, enc_a_i};

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < 2; i++) begin
            if (&hist_q[i]) begin
                level_d[i] = 1'b1;
            end else if (~|hist_q[i]) begin
                level_d[i] = 1'b0;
            end
        end
    end

    assign step = quad_step(level_q[0], level_q[1], prev_q[0], prev_q[1]);

    always_comb begin
        value_d = value_q;
        unique case (step)
            StepInc: value_d = value_q + level_t'(1);
            StepDec: value_d = value_q - level_t'(1);
            default: value_d = value_q;
        endcase
    end

    assign pwm_d = (counter_i < value_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < 2; i++) begin
                hist_q[i] <= '0;
            end
            level_q <= '0;
            prev_q  <= '0;
            value_q <= '0;
            pwm_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                hist_q[i] <= {hist_q[i][DebounceLen-2:0], sync2_q[i]};
            end
            level_q <= level_d;
            prev_q  <= level_q;
            value_q <= value_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_mixer_core.sv
// Three-channel rotary-encoder RGB LED mixer; one free-running counter is shared
// by all three PWM comparators.
module rgb_mixer_core
    import rgb_mixer_pkg::*;
#(
    parameter int unsigned DebounceLen = DEBOUNCE_LEN
) (
    input  logic clk,
    input  logic resetb,
    input  logic enc0_a,
    input  logic enc0_b,
    input  logic enc1_a,
    input  logic enc1_b,
    input  logic enc2_a,
    input  logic enc2_b,
    output logic pwm0_out,
    output logic pwm1_out,
    output logic pwm2_out
);

    level_t     counter_q;
    logic [2:0] enc_a;
    logic [2:0] enc_b;
    logic [2:0] pwm;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_q + level_t'(1);
        end
    end

    assign enc_a = {enc2_a, enc1_a, enc0_a};
    assign enc_b = {enc2_b, enc1_b, enc0_b};

    for (genvar ch = 0; ch < 3; ch++) begin : g_channel
        rgb_mixer_channel #(
            .DebounceLen(DebounceLen)
        ) u_channel (
            .clk_i    (clk),
            .rst_ni   (resetb),
            .enc_a_i  (enc_a[ch]),
            .enc_b_i  (enc_b[ch]),
            .counter_i(counter_q),
            .pwm_o    (pwm[ch])
        );
    end

    assign pwm0_out = pwm[0];
    assign pwm1_out = pwm[1];
    assign pwm2_out = pwm[2];

endmodule

// File: tb/tb_rgb_mixer_core.sv
// Directed bench for rgb_mixer_core: encoder step vectors checked through PWM duty.
module tb_rgb_mixer_core;

    logic       clk;
    logic       resetb;
    logic [2:0] enc_a;
    logic [2:0] enc_b;
    logic       pwm0_out;
    logic       pwm1_out;
    logic       pwm2_out;

    int checks;
    int errors;
    int phase [3];

    rgb_mixer_core dut (
        .clk     (clk),
        .resetb  (resetb),
        .enc0_a  (enc_a[0]),
        .enc0_b  (enc_b[0]),
        .enc1_a  (enc_a[1]),
        .enc1_b  (enc_b[1]),
        .enc2_a  (enc_a[2]),
        .enc2_b  (enc_b[2]),
        .pwm0_out(pwm0_out),
        .pwm1_out(pwm1_out),
        .pwm2_out(pwm2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int ch;
        bit cw;
        int steps;
        int exp0;
        int exp1;
        int exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Gray sequence in clockwise order: (a,b) = 00, 10, 11, 01.
    task automatic drive_phase(input int ch);
        case (phase[ch])
            0:       begin enc_a[ch] = 1'b0; enc_b[ch] = 1'b0; end
            1:       begin enc_a[ch] = 1'b1; enc_b[ch] = 1'b0; end
            2:       begin enc_a[ch] = 1'b1; enc_b[ch] = 1'b1; end
            default: begin enc_a[ch] = 1'b0; enc_b[ch] = 1'b1; end
        endcase
    endtask

    task automatic step(input int ch, input bit cw);
        phase[ch] = cw ? (phase[ch] + 1) % 4 : (phase[ch] + 3) % 4;
        drive_phase(ch);
        repeat (20) @(posedge clk);
    endtask

    task automatic step_mask(input logic [2:0] m);
        for (int ch = 0; ch < 3; ch++) begin
            if (m[ch]) begin
                phase[ch] = (phase[ch] + 1) % 4;
                drive_phase(ch);
            end
        end
        repeat (20) @(posedge clk);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        enc_a  = '0;
        enc_b  = '0;
        for (int ch = 0; ch < 3; ch++) phase[ch] = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic measure(input int n, output int d0, output int d1, output int d2);
        d0 = 0;
        d1 = 0;
        d2 = 0;
        repeat (n) begin
            @(negedge clk);
            d0 += int'(pwm0_out);
            d1 += int'(pwm1_out);
            d2 += int'(pwm2_out);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, d1, d2;
        int k;
        checks = 0;
        errors = 0;

        // Each full clockwise detent counts +2; counter-clockwise counts -2.
        vecs[0] = '{1'b1, 0, 1'b1, 0,  0,   0,   0};
        vecs[1] = '{1'b1, 0, 1'b1, 20, 10,  0,   0};
        vecs[2] = '{1'b1, 1, 1'b0, 1,  0,   255, 0};
        vecs[3] = '{1'b0, 1, 1'b1, 1,  0,   255, 0};
        vecs[4] = '{1'b0, 2, 1'b1, 3,  0,   255, 2};
        vecs[5] = '{1'b0, 2, 1'b0, 2,  0,   255, 1};
        vecs[6] = '{1'b0, 0, 1'b0, 4,  254, 255, 1};
        vecs[7] = '{1'b0, 1, 1'b1, 1,  254, 0,   1};

        // Reset state, then idle for 512 cycles.
        resetb = 1'b0;
        enc_a  = '0;
        enc_b  = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset pwm0", int'(pwm0_out), 0);
        check("reset pwm1", int'(pwm1_out), 0);
        check("reset pwm2", int'(pwm2_out), 0);
        resetb = 1'b1;
        measure(512, d0, d1, d2);
        check("idle512 pwm0", d0, 0);
        check("idle512 pwm1", d1, 0);
        check("idle512 pwm2", d2, 0);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].rst) do_reset();
            for (int s = 0; s < vecs[v].steps; s++) step(vecs[v].ch, vecs[v].cw);
            repeat (5) @(posedge clk);
            measure(256, d0, d1, d2);
            check($sformatf("vec%0d duty0", v), d0, vecs[v].exp0);
            check($sformatf("vec%0d duty1", v), d1, vecs[v].exp1);
            check($sformatf("vec%0d duty2", v), d2, vecs[v].exp2);
        end

        // Simultaneous A/B change is an invalid transition and must not count.
        enc_a[0] = 1'b1;
        enc_b[0] = 1'b1;
        repeat (20) @(posedge clk);
        enc_a[0] = 1'b0;
        enc_b[0] = 1'b0;
        repeat (20) @(posedge clk);
        measure(256, d0, d1, d2);
        check("invalid duty0", d0, 254);

        // Debounce: 5-cycle glitch ignored, 12-cycle pulse accepted as one A rise.
        do_reset();
        @(negedge clk);
        enc_a[2] = 1'b1;
        repeat (5) @(negedge clk);
        enc_a[2] = 1'b0;
        repeat (20) @(posedge clk);
        measure(256, d0, d1, d2);
        check("glitch duty2", d2, 0);
        @(negedge clk);
        enc_a[2] = 1'b1;
        repeat (12) @(negedge clk);
        enc_a[2] = 1'b0;
        repeat (20) @(posedge clk);
        measure(256, d0, d1, d2);
        check("pulse12 duty2", d2, 1);

        // Concurrent drive to 0x40 / 0x80 / 0xC0.
        do_reset();
        for (int i = 0; i < 96; i++) begin
            repeat (4) step_mask({i < 96, i < 64, i < 32});
        end
        repeat (5) @(posedge clk);
        measure(256, d0, d1, d2);
        check("concurrent duty0", d0, 64);
        check("concurrent duty1", d1, 128);
        check("concurrent duty2", d2, 192);

        // Mid-operation reset while enc1 (value 0x80) has an edge in flight.
        enc_a[1] = 1'b1;
        repeat (6) @(posedge clk);
        k = 0;
        @(negedge clk);
        while (!pwm1_out && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("midop pwm1 high", int'(pwm1_out), 1);
        @(posedge clk);
        #2;
        resetb = 1'b0;
        enc_a  = '0;
        enc_b  = '0;
        #1;
        check("async pwm0", int'(pwm0_out), 0);
        check("async pwm1", int'(pwm1_out), 0);
        check("async pwm2", int'(pwm2_out), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetb = 1'b1;
        for (int ch = 0; ch < 3; ch++) phase[ch] = 0;
        repeat (20) @(posedge clk);
        measure(256, d0, d1, d2);
        check("post-reset duty0", d0, 0);
        check("post-reset duty1", d1, 0);
        check("post-reset duty2", d2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
